carrier_sync_ctrl: RTL

//  Configuration sequencer for the NCH 16-bit carrier generators of the pwm8carr block. Holds staging/active copies of

---
 rtl/carrier_sync_ctrl_pkg.sv | 36 +++
 rtl/carrier_evt_det.sv | 34 +++
 rtl/carrier_sync_ctrl.sv | 142 ++++++++++++++
 3 files changed

// File: rtl/carrier_sync_ctrl_pkg.sv
// Shared types for the carrier configuration sequencer: count/on-off encodings,
// update-point selection and the sequencer state.
package carrier_sync_ctrl_pkg;

    localparam int PWMCOUNT_WIDTH = 16;

    typedef enum logic [1:0] {
        NO_COUNT     = 2'd0,
        COUNT_UP     = 2'd1,
        COUNT_DOWN   = 2'd2,
        COUNT_UPDOWN = 2'd3
    } count_mode_e;

    typedef enum logic {
        PWM_OFF = 1'b0,
        PWM_ON  = 1'b1
    } pwm_onoff_e;

    typedef enum logic [1:0] {
        UPD_NOW  = 2'd0,
        UPD_ZERO = 2'd1,
        UPD_PEAK = 2'd2,
        UPD_BOTH = 2'd3
    } upd_mode_e;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_ARMED   = 2'd1,
        S_APPLY   = 2'd2,
        S_RESTART = 2'd3
    } ctrl_state_e;

    // Cycles the generators are left counting after restart before commit_done.
    localparam logic [1:0] RESTART_HOLD = 2'd2;

endpackage

// File: rtl/carrier_evt_det.sv
// Detects the zero-crossing and peak-reach events of the reference carrier,
// using the previous-cycle carrier value for edge qualification.
module carrier_evt_det
    import carrier_sync_ctrl_pkg::*;
#(
    parameter int CW = PWMCOUNT_WIDTH
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [CW-1:0] carrier_ref,
    input  logic [CW-1:0] period,
    output logic          zero_evt,
    output logic          peak_evt
);

    logic [CW-1:0] cr_q;
    logic [CW:0]   pk_thr;

    always_ff @(posedge clk) begin
        if (reset) begin
            cr_q <= '0;
        end else begin
            cr_q <= carrier_ref;
        end
    end

    // One extra bit so period==0 cannot wrap the threshold into a false match.
    assign pk_thr   = {1'b0, period} - {{CW{1'b0}}, 1'b1};
    assign zero_evt = (carrier_ref == '0) && (cr_q != '0);
    assign peak_evt = (period != '0)
                   && ({1'b0, carrier_ref} >= pk_thr)
                   && ({1'b0, cr_q} < pk_thr);

endmodule

// File: rtl/carrier_sync_ctrl.sv
// Staging/active configuration sequencer for the carrier generators: commits are
// applied at a chosen carrier event, optionally with a coherent stop/restart re-phase.
module carrier_sync_ctrl
    import carrier_sync_ctrl_pkg::*;
#(
    parameter int NCH = 8,
    parameter int CW  = PWMCOUNT_WIDTH
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cfg_commit,
    input  logic [CW-1:0]     cfg_period,
    input  logic [1:0]        cfg_mode,
    input  logic              cfg_onoff,
    input  logic [NCH*CW-1:0] cfg_phase,
    input  logic [1:0]        cfg_upd,
    input  logic              cfg_resync,
    input  logic [CW-1:0]     carrier_ref,
    output logic [CW-1:0]     period_o,
    output logic [1:0]        count_mode_o,
    output logic              pwm_onoff_o,
    output logic [NCH*CW-1:0] init_carr_o,
    output logic              busy,
    output logic              commit_done,
    output logic              cfg_err
);

    ctrl_state_e       state, state_n;
    logic [1:0]        rs_cnt;
    logic [CW-1:0]     stg_period;
    logic [1:0]        stg_mode;
    logic              stg_onoff;
    logic [NCH*CW-1:0] stg_phase;
    upd_mode_e         stg_upd;
    logic              stg_resync;
    logic              zero_evt, peak_evt;
    logic              running, fire, accept, done_n, err_n;

    function automatic logic cfg_valid(input logic [CW-1:0]     per,
                                       input logic              onoff,
                                       input logic [NCH*CW-1:0] ph);
        logic ok;
        ok = !((per == '0) && (onoff == PWM_ON));
        for (int i = 0; i < NCH; i++) begin
            if (ph[i*CW +: CW] > per) ok = 1'b0;
        end
        return ok;
    endfunction

    carrier_evt_det #(.CW(CW)) u_evt (
        .clk         (clk),
        .reset       (reset),
        .carrier_ref (carrier_ref),
        .period      (period_o),
        .zero_evt    (zero_evt),
        .peak_evt    (peak_evt)
    );

    // A stopped carrier never produces events, so an armed update goes out at once.
    assign running = (pwm_onoff_o == PWM_ON) && (count_mode_o != NO_COUNT) && (period_o != '0);
    assign fire    = !running
                  || (stg_upd == UPD_NOW)
                  || (((stg_upd == UPD_ZERO) || (stg_upd == UPD_BOTH)) && zero_evt)
                  || (((stg_upd == UPD_PEAK) || (stg_upd == UPD_BOTH)) && peak_evt);
    assign busy    = (state != S_IDLE);

    always_comb begin
        state_n = state;
        accept  = 1'b0;
        done_n  = 1'b0;
        err_n   = 1'b0;
        if (cfg_commit) begin
            if (((state == S_IDLE) || (state == S_ARMED)) && cfg_valid(cfg_period, cfg_onoff, cfg_phase)) begin
                accept = 1'b1;
            end else begin
                err_n = 1'b1;
            end
        end
        case (state)
            S_IDLE:    if (accept) state_n = S_ARMED;
            S_ARMED:   if (fire) state_n = S_APPLY;
            S_APPLY: begin
                if (stg_resync) begin
                    state_n = S_RESTART;
                end else begin
                    state_n = S_IDLE;
                    done_n  = 1'b1;
                end
            end
            S_RESTART: begin
                if (rs_cnt == RESTART_HOLD) begin
                    state_n = S_IDLE;
                    done_n  = 1'b1;
                end
            end
            default:   state_n = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= S_IDLE;
            rs_cnt       <= '0;
            commit_done  <= 1'b0;
            cfg_err      <= 1'b0;
            period_o     <= '0;
            count_mode_o <= NO_COUNT;
            pwm_onoff_o  <= PWM_OFF;
            init_carr_o  <= '0;
            stg_period   <= '0;
            stg_mode     <= NO_COUNT;
            stg_onoff    <= PWM_OFF;
            stg_phase    <= '0;
            stg_upd      <= UPD_NOW;
            stg_resync   <= 1'b0;
        end else begin
            state       <= state_n;
            commit_done <= done_n;
            cfg_err     <= err_n;
            rs_cnt      <= (state == S_RESTART) ? rs_cnt + 2'd1 : 2'd0;
            if (accept) begin
                stg_period <= cfg_period;
                stg_mode   <= cfg_mode;
                stg_onoff  <= cfg_onoff;
                stg_phase  <= cfg_phase;
                stg_upd    <= upd_mode_e'(cfg_upd);
                stg_resync <= cfg_resync;
            end
            // Holding on/off low for one cycle makes every generator reload init_carr together.
            if (state == S_APPLY) begin
                period_o     <= stg_period;
                count_mode_o <= stg_mode;
                init_carr_o  <= stg_phase;
                pwm_onoff_o  <= stg_resync ? PWM_OFF : stg_onoff;
            end
            if ((state == S_RESTART) && (rs_cnt == 2'd0)) begin
                pwm_onoff_o <= stg_onoff;
            end
        end
    end

endmodule
